fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the 16-bit processor, directly downstream of the program counting system. It captures the current PC and runs a request/ready handshake with instruction memory. It latches the returned word into the instruction register and produces the sign-extended immediate that feeds back to the PC logic's ImR input. A flush input abandons an in-flight fetch, and a watchdog counter substitutes a NOP when memory never answers.

## Interface
- IMM_WIDTH, 8: immediate field width; immediate is IR[IMM_WIDTH-1:0]; legal range 1..15.
- TIMEOUT, 15: maximum WAIT cycles before the fetch is abandoned; legal range 1..255.
- NOP_WORD, 16'h0000: word loaded into IR on timeout.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- PC  in  16  address of the instruction to fetch; sampled on fetch start.
- fetch_start  in  1  control request to begin a fetch.
- flush  in  1  discards the fetch in progress (branch/restore taken).
- mem_rdata  in  16  instruction memory read data.
- mem_ready  in  1  memory data valid; honoured only while mem_req=1.
- mem_addr  out  16  fetch address held for the whole request.
- mem_req  out  1  read request to instruction memory.
- IR  out  16  instruction register.
- ImR  out  16  sign-extended immediate of IR.
- instr_pc  out  16  address from which IR was fetched.
- fetch_done  out  1  one-cycle pulse: IR/ImR/instr_pc updated.
- fetch_err  out  1  one-cycle pulse with fetch_done when the fetch timed out.
- busy  out  1  high in WAIT and DONE.

## Operation
- FSM states: IDLE, WAIT, DONE. All outputs are decoded from registers only, with no combinational input-to-output path.
- IDLE: fetch_start=1 → mem_addr<=PC, wait counter<=0, go to WAIT. flush in IDLE has no effect.
- WAIT: mem_req=1 and mem_addr stays stable. Priority order within a cycle:
  - flush=1 → IDLE. IR, ImR, instr_pc unchanged and no fetch_done. Flush beats a same-cycle mem_ready.
  - mem_ready=1 → IR<=mem_rdata, instr_pc<=mem_addr, go to DONE.
  - counter==TIMEOUT-1 → IR<=NOP_WORD, instr_pc<=mem_addr, set error flag, go to DONE.
  - otherwise counter increments.
- DONE: fetch_done=1, plus fetch_err=1 if the error flag is set. Next state:
  - WAIT if fetch_start=1, with mem_addr<=PC sampled this cycle (back-to-back fetch).
  - IDLE otherwise.
  - flush in DONE does not retract the completed fetch. It cancels a same-cycle fetch_start, and the FSM goes to IDLE.
- ImR = {{(16-IMM_WIDTH){IR[IMM_WIDTH-1]}}, IR[IMM_WIDTH-1:0]}. It is registered alongside IR and is never stale relative to IR.
- mem_rdata is ignored outside WAIT. mem_ready outside WAIT is ignored without error.
- Error flag clears on entry to WAIT and on reset.

## Timing
- Reset (synchronous, clk edge with reset=1): state IDLE; IR, ImR, instr_pc, mem_addr = 16'h0000; mem_req, fetch_done, fetch_err, busy = 0; counter = 0.
- Reset overrides every other input, including mid-WAIT. mem_req drops on the cycle after the reset edge.
- Latency: fetch_start at edge N → mem_req high from N+1. mem_ready seen at edge N+k (k≥1) → fetch_done high during cycle N+k+1, with IR valid in that same cycle.
- Minimum fetch, with mem_ready already high on the first WAIT cycle: 2 cycles from start to fetch_done. Back-to-back throughput is 1 instruction per 2 cycles.
- Timeout: with mem_ready held low, fetch_done+fetch_err assert exactly TIMEOUT+1 cycles after the fetch_start edge.
- The PC logic may update PC any time after fetch_start is sampled; mem_addr does not follow PC changes during WAIT.

## Test plan
- Reset behaviour: assert reset mid-WAIT with mem_addr=16'h0042 → next cycle mem_req=0, busy=0, IR=0, ImR=0, mem_addr=0; a later mem_ready=1 is ignored.
- Basic fetch: PC=16'h0010, fetch_start pulse, mem_ready=1 on the first WAIT cycle with mem_rdata=16'hA3F5 → fetch_done 2 cycles after start; IR=16'hA3F5, ImR=16'hFFF5, instr_pc=16'h0010, fetch_err=0.
- Positive immediate and wait states: mem_ready delayed 3 cycles, mem_rdata=16'h1207 → fetch_done on cycle 5; ImR=16'h0007; mem_addr held constant throughout while PC is changed during WAIT.
- Flush priority: flush=1 and mem_ready=1 in the same WAIT cycle → IDLE, no fetch_done pulse, IR keeps its previous value.
- Timeout: TIMEOUT=4, mem_ready held 0 → fetch_done and fetch_err high together 5 cycles after start; IR=NOP_WORD; the next successful fetch shows fetch_err=0.
- Back-to-back: fetch_start held high, PC stepping 16'h0000, 16'h0001, 16'h0002 with mem_ready always 1 → fetch_done every 2nd cycle; instr_pc sequence 0, 1, 2 with the matching IR values.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Captures the PC, runs a req/ready
//            handshake with instruction memory, latches IR together with
//            its sign-extended immediate, supports flush and substitutes a
//            NOP word when memory fails to answer within TIMEOUT cycles.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int          IMM_WIDTH = 8,
    parameter int          TIMEOUT   = 15,
    parameter logic [15:0] NOP_WORD  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] PC,
    input  logic        fetch_start,
    input  logic        flush,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    output logic [15:0] IR,
    output logic [15:0] ImR,
    output logic [15:0] instr_pc,
    output logic        fetch_done,
    output logic        fetch_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last counter value before the fetch is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] imr_q, imr_d;
    logic [15:0] ipc_q, ipc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    // Sign-extend the immediate field to the full 16-bit word.
    function automatic logic [15:0] sext_imm(input logic [IMM_WIDTH-1:0] f);
        return {{(16-IMM_WIDTH){f[IMM_WIDTH-1]}}, f};
    endfunction

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 16'h0000;
            ir_q    <= 16'h0000;
            imr_q   <= 16'h0000;
            ipc_q   <= 16'h0000;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            imr_q   <= imr_d;
            ipc_q   <= ipc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: flush beats ready, ready beats timeout.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        imr_d   = imr_q;
        ipc_d   = ipc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_start) begin
                    state_d = S_WAIT;
                    addr_d  = PC;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mem_ready) begin
                    ir_d    = mem_rdata;
                    imr_d   = sext_imm(mem_rdata[IMM_WIDTH-1:0]);
                    ipc_d   = addr_q;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    ir_d    = NOP_WORD;
                    imr_d   = sext_imm(NOP_WORD[IMM_WIDTH-1:0]);
                    ipc_d   = addr_q;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                // A completed fetch stands; flush only cancels a new start.
                if (fetch_start && !flush) begin
                    state_d = S_WAIT;
                    addr_d  = PC;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr   = addr_q;
    assign mem_req    = (state_q == S_WAIT);
    assign IR         = ir_q;
    assign ImR        = imr_q;
    assign instr_pc   = ipc_q;
    assign fetch_done = (state_q == S_DONE);
    assign fetch_err  = (state_q == S_DONE) && err_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A driver issues fetches and
//            queues the expected result of each; a monitor compares every
//            fetch_done pulse against the head of the queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam int          IMM = 8;
    localparam int          TO  = 4;
    localparam logic [15:0] NOP = 16'h8C01;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] PC = 16'h0000;
    logic        fetch_start = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic [15:0] IR;
    logic [15:0] ImR;
    logic [15:0] instr_pc;
    logic        fetch_done;
    logic        fetch_err;
    logic        busy;

    fetch_unit #(.IMM_WIDTH(IMM), .TIMEOUT(TO), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .PC(PC), .fetch_start(fetch_start),
        .flush(flush), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_req(mem_req), .IR(IR), .ImR(ImR),
        .instr_pc(instr_pc), .fetch_done(fetch_done), .fetch_err(fetch_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] imr;
        logic [15:0] pc;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] last_ir = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference immediate: low IMM bits read as a two's-complement number.
    function automatic logic [15:0] ref_imm(input logic [15:0] w);
        int m;
        int v;
        m = 1 << IMM;
        v = int'(w) % m;
        if (v >= m / 2) v = v - m;
        return 16'(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every fetch_done pulse must match the oldest queued fetch.
    always @(negedge clk) begin
        if (fetch_done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got fetch_done=1 expected no pending fetch (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("IR", IR, mon_e.ir);
                chk("ImR", ImR, mon_e.imr);
                chk("instr_pc", instr_pc, mon_e.pc);
                chk("fetch_err", fetch_err, mon_e.err);
                chk("done_cycle", cyc, mon_e.cyc);
            end
        end else if (fetch_err) begin
            chk("err_without_done", fetch_err, 1'b0);
        end
    end

    // One fetch: memory answers after d empty WAIT cycles, flush at WAIT
    // cycle fl (-1 = none); optionally flush+start together in DONE.
    task automatic fetch(input logic [15:0] pc, input logic [15:0] data,
                         input int d, input int fl, input bit done_flush);
        int   last;
        bit   flushed;
        exp_t e;
        last    = (d < TO - 1) ? d : TO - 1;
        flushed = (fl >= 0) && (fl <= last);
        PC = pc;
        fetch_start = 1'b1;
        if (!flushed) begin
            e.ir  = (d <= TO - 1) ? data : NOP;
            e.err = (d > TO - 1);
            e.imr = ref_imm(e.ir);
            e.pc  = pc;
            e.cyc = cyc + 2 + last;
            q.push_back(e);
        end
        tick;
        fetch_start = 1'b0;
        for (int j = 0; j <= last; j++) begin
            chk("mem_req_wait", mem_req, 1'b1);
            chk("mem_addr_held", mem_addr, pc);
            PC        = 16'($urandom);
            mem_ready = (j == d);
            mem_rdata = (j == d) ? data : 16'($urandom);
            flush     = (j == fl);
            tick;
            if (j == fl) break;
        end
        mem_ready = 1'b0;
        flush     = 1'b0;
        mem_rdata = 16'($urandom);
        if (flushed) begin
            chk("flush_busy", busy, 1'b0);
            chk("flush_IR_kept", IR, last_ir);
        end else begin
            last_ir = e.ir;
            if (done_flush) begin
                fetch_start = 1'b1;
                flush       = 1'b1;
                mem_ready   = 1'b1;
                PC          = 16'($urandom);
            end
            tick;
            fetch_start = 1'b0;
            flush       = 1'b0;
            mem_ready   = 1'b0;
            chk("idle_after_done", busy, 1'b0);
        end
    endtask

    // Back-to-back: fetch_start held, memory always ready, PC stepping.
    task automatic b2b(input logic [15:0] base, input int n);
        logic [15:0] data[8];
        exp_t        e;
        int          s0;
        for (int k = 0; k < n; k++) data[k] = 16'($urandom);
        s0 = cyc + 1;
        mem_ready = 1'b1;
        for (int i = 0; i < 2 * n; i++) begin
            fetch_start = (i < 2 * n - 1);
            PC          = base + 16'(i / 2);
            mem_rdata   = data[i / 2];
            if (i % 2 == 0) begin
                e.ir  = data[i / 2];
                e.imr = ref_imm(data[i / 2]);
                e.pc  = base + 16'(i / 2);
                e.err = 1'b0;
                e.cyc = s0 + i + 1;
                q.push_back(e);
            end
            tick;
        end
        fetch_start = 1'b0;
        tick;
        mem_ready = 1'b0;
        chk("b2b_idle", busy, 1'b0);
        last_ir = data[n - 1];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_IR", IR, 16'h0000);
        chk("rst_ImR", ImR, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_done", fetch_done, 1'b0);
        tick;

        fetch(16'h0010, 16'hA3F5, 0, -1, 1'b0);   // basic, negative imm
        fetch(16'h0020, 16'h1207, 3, -1, 1'b0);   // wait states, positive imm
        fetch(16'h0030, 16'h5555, 0, 0, 1'b0);    // flush beats ready
        fetch(16'h0040, 16'h7777, 10, -1, 1'b0);  // timeout -> NOP
        fetch(16'h0050, 16'h0080, 1, -1, 1'b0);   // success clears error
        fetch(16'h0060, 16'h00FF, 0, -1, 1'b1);   // flush+start in DONE
        b2b(16'h0000, 3);

        for (int n = 0; n < 40; n++) begin
            int d;
            int fl;
            d  = int'($urandom_range(0, TO + 2));
            fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, TO)) : -1;
            fetch(16'($urandom), 16'($urandom), d, fl, $urandom_range(0, 3) == 0);
        end
        b2b(16'($urandom), 4);

        // Reset in the middle of a fetch.
        PC = 16'h0042;
        fetch_start = 1'b1;
        tick;
        fetch_start = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("midrst_mem_req", mem_req, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_IR", IR, 16'h0000);
        chk("midrst_ImR", ImR, 16'h0000);
        chk("midrst_mem_addr", mem_addr, 16'h0000);
        chk("midrst_instr_pc", instr_pc, 16'h0000);
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        repeat (3) tick;
        mem_ready = 1'b0;
        chk("midrst_ready_ignored", IR, 16'h0000);
        last_ir = 16'h0000;
        fetch(16'h0070, 16'h3C81, 2, -1, 1'b0);

        repeat (3) tick;
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
